// File: rtl/pwm_ramp.sv
// pwm_ramp
//   PWM generator whose duty cycle ramps up to a programmable peak and back
//   down to zero, advancing one count per qualified step pulse.
//
// Parameters
//   N         duty and PWM counter width in bits
//
// Ports
//   clk       single clock, all state on the rising edge
//   rst       asynchronous active-low reset
//   ena       block enable; when low the PWM counter is held at 0,
//             pwm/wrap are forced low and the ramp state holds
//   step      ramp-advance request, sampled every cycle (level, not edge)
//   max_duty  ramp peak, sampled on each qualified step
//   pwm       PWM waveform: ena & (counter < duty_active)
//   duty      current ramp duty register
//   dir       ramp direction, 1 = up, 0 = down
//   wrap      high while the PWM counter sits at 2^N-1 with ena high

module pwm_ramp #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic         step,
    input  logic [N-1:0] max_duty,
    output logic         pwm,
    output logic [N-1:0] duty,
    output logic         dir,
    output logic         wrap
);

    typedef enum logic {
        DOWN = 1'b0,
        UP   = 1'b1
    } state_e;

    state_e       state_q, state_d;
    logic [N-1:0] cnt_q, cnt_d;
    logic [N-1:0] duty_q, duty_d;
    logic [N-1:0] act_q, act_d;

    logic         adv;
    logic [N:0]   duty_inc;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= UP;
            cnt_q   <= '0;
            duty_q  <= '0;
            act_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            duty_q  <= duty_d;
            act_q   <= act_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic: ramp FSM, PWM counter, period-latched duty
    // ------------------------------------------------------------------
    assign adv      = step & ena;
    // One bit wider so duty = 2^N-1 cannot wrap and look smaller than the peak.
    assign duty_inc = {1'b0, duty_q} + (N+1)'(1);

    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        if (adv) begin
            unique case (state_q)
                UP: begin
                    if (max_duty == '0) begin
                        // Zero peak: stay parked at 0 going up.
                        duty_d = '0;
                    end else if (duty_inc < {1'b0, max_duty}) begin
                        duty_d = duty_inc[N-1:0];
                    end else begin
                        // Reached the peak, or the peak was lowered below us.
                        duty_d  = max_duty;
                        state_d = DOWN;
                    end
                end
                DOWN: begin
                    if (duty_q > N'(1)) begin
                        duty_d = duty_q - N'(1);
                    end else begin
                        duty_d  = '0;
                        state_d = UP;
                    end
                end
                default: begin
                    state_d = UP;
                end
            endcase
        end
    end

    always_comb begin
        cnt_d = '0;
        if (ena) begin
            cnt_d = cnt_q + N'(1);
        end
    end

    // duty_active only changes at the period boundary; on a coincident
    // step the pre-step duty_q is captured here.
    always_comb begin
        act_d = act_q;
        if (wrap) begin
            act_d = duty_q;
        end
    end

    // ------------------------------------------------------------------
    // Outputs (combinational from registers and ena only)
    // ------------------------------------------------------------------
    always_comb begin
        dir  = (state_q == UP);
        duty = duty_q;
        wrap = ena & (cnt_q == '1);
        pwm  = ena & (cnt_q < act_q);
    end

endmodule
